ofm_requant_collector: RTL and testbench

Downstream of `conv2d_3x3`, this block takes the `COL` per-column partial-sum streams (`sum[col]` qualified by `sum_valid[col]`, which cannot be back-pressured) and buffers each column in its own FIFO. It arbitrates the columns round-robin, requantizes each sum to int8 (bias add, rounded arithmetic right shift, optional ReLU, saturation) and emits one valid/ready byte stream tagged with the source column. It is the boundary between the PE array and the OFM write-back path.

---
 rtl/conv_pkg.sv | 40 ++++
 rtl/ofm_requant_collector_if.sv | 31 +++
 rtl/ofm_requant_collector_sum_fifo.sv | 64 ++++++
 rtl/ofm_requant_collector.sv | 162 ++++++++++++++++
 tb/tb_ofm_requant_collector.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Types and constants shared along the convolution datapath, together with
// the int8 requantization helper used by the OFM collector.
//   sum_t   : signed PE-array column partial sum
//   ofm_t   : signed int8 output feature-map element
//   acc_t   : sum + bias, wide enough to never overflow
//   requant : rounded arithmetic shift, optional ReLU, saturation to int8
// ---------------------------------------------------------------------------
package conv_pkg;

   localparam int OFM_W = 24;

   typedef logic signed [OFM_W-1:0] sum_t;
   typedef logic signed [7:0]       ofm_t;
   typedef logic signed [32:0]      acc_t;

   localparam ofm_t INT8_MAX = 8'sd127;
   localparam ofm_t INT8_MIN = -8'sd128;

   // One extra bit over acc_t so that adding the rounding constant to the
   // largest possible acc cannot wrap.
   function automatic ofm_t requant(acc_t acc, logic [4:0] shift, logic relu);
      logic signed [33:0] r;
      r = 34'(acc);
      if (shift != 5'd0) begin
         r = (r + (34'sd1 <<< (shift - 5'd1))) >>> shift;
      end
      if (relu && (r < 34'sd0)) begin
         r = '0;
      end
      if (r > 34'(INT8_MAX)) begin
         return INT8_MAX;
      end else if (r < 34'(INT8_MIN)) begin
         return INT8_MIN;
      end
      return ofm_t'(r[7:0]);
   endfunction

endpackage

// File: rtl/ofm_requant_collector_if.sv
// ---------------------------------------------------------------------------
// ofm_requant_collector_if
// Bundles the per-column sum strobes coming from the PE array and the
// requantized int8 output stream.
//   sum_valid/sum : COL non-back-pressurable partial-sum streams
//   out_valid/out_ready/out_data/out_col : valid/ready byte stream with tag
// Modports: master = collector side, slave = PE array / write-back side.
// ---------------------------------------------------------------------------
interface ofm_requant_collector_if #(
   parameter int COL       = 8,
   parameter int OFM_WIDTH = 24
);
   localparam int COL_W = (COL > 1) ? $clog2(COL) : 1;

   logic [COL-1:0]              sum_valid;
   logic signed [OFM_WIDTH-1:0] sum [COL];
   logic                        out_valid;
   logic                        out_ready;
   logic signed [7:0]           out_data;
   logic [COL_W-1:0]            out_col;

   modport master (
      input  sum_valid, sum, out_ready,
      output out_valid, out_data, out_col
   );

   modport slave (
      output sum_valid, sum, out_ready,
      input  out_valid, out_data, out_col
   );
endinterface

// File: rtl/ofm_requant_collector_sum_fifo.sv
// ---------------------------------------------------------------------------
// sum_fifo
// Single-clock synchronous FIFO for one column of partial sums. Full/empty
// are decoded from a registered occupancy count, so a push into an empty
// FIFO becomes poppable the following cycle (no bypass).
//   clk, rst  : clock, synchronous active-high reset
//   clr       : synchronous flush
//   push, din : write request / data (accepted when not full or popping)
//   pop, dout : read request / head-of-queue data
//   full, empty
// ---------------------------------------------------------------------------
module sum_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    push,
   input  logic signed [WIDTH-1:0] din,
   input  logic                    pop,
   output logic signed [WIDTH-1:0] dout,
   output logic                    full,
   output logic                    empty
);
   localparam int AW = $clog2(DEPTH);

   logic signed [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic [AW:0]             count;
   logic                    wr_en;
   logic                    rd_en;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign dout  = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; occupancy alone decides which
   // entries are meaningful, and a resettable array would not map to RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/ofm_requant_collector.sv
// ---------------------------------------------------------------------------
// ofm_requant_collector
// Buffers COL partial-sum streams in per-column FIFOs, arbitrates them
// round-robin, requantizes each sum to int8 and emits one tagged byte stream.
//   clk, rst            : clock, synchronous active-high reset
//   start               : latch cfg, flush FIFOs/pipeline, clear counter/ovf
//   cfg_bias/shift/relu : requantization parameters
//   cfg_total           : handshakes per done pulse (0 = never)
//   ofm                 : sum inputs and output byte stream (master modport)
//   done                : one-cycle pulse after the cfg_total-th handshake
//   ovf                 : sticky, a sum arrived at a full FIFO and was lost
// Pipeline: FIFO -> S1 (bias add) -> output register (requant).
// ---------------------------------------------------------------------------
module ofm_requant_collector
   import conv_pkg::*;
#(
   parameter int COL        = 8,
   parameter int OFM_WIDTH  = OFM_W,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_WIDTH  = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic signed [31:0]   cfg_bias,
   input  logic [4:0]           cfg_shift,
   input  logic                 cfg_relu,
   input  logic [CNT_WIDTH-1:0] cfg_total,
   ofm_requant_collector_if.master ofm,
   output logic                 done,
   output logic                 ovf
);
   localparam int COL_W = (COL > 1) ? $clog2(COL) : 1;

   logic signed [31:0]          cfg_bias_q;
   logic [4:0]                  cfg_shift_q;
   logic                        cfg_relu_q;
   logic [CNT_WIDTH-1:0]        cfg_total_q;

   logic [COL-1:0]              f_push, f_pop, f_full, f_empty, f_drop;
   logic signed [OFM_WIDTH-1:0] f_dout [COL];

   logic [COL_W-1:0]            rr_ptr;
   logic                        gnt_valid;
   logic [COL_W-1:0]            gnt_col;

   logic                        s1_valid;
   acc_t                        s1_acc;
   logic [COL_W-1:0]            s1_col;

   logic                        out_valid_q;
   ofm_t                        out_data_q;
   logic [COL_W-1:0]            out_col_q;
   logic [CNT_WIDTH-1:0]        cnt_q;

   logic                        out_load, s1_adv, pop_any, hs;

   assign out_load = !out_valid_q || ofm.out_ready;
   assign s1_adv   = !s1_valid || out_load;
   assign pop_any  = gnt_valid && s1_adv;
   assign hs       = out_valid_q && ofm.out_ready;

   assign ofm.out_valid = out_valid_q;
   assign ofm.out_data  = out_data_q;
   assign ofm.out_col   = out_col_q;

   for (genvar c = 0; c < COL; c++) begin : g_col
      // Pushes in the start cycle are discarded; the FIFO is being flushed.
      assign f_push[c] = ofm.sum_valid[c] && !start;
      assign f_pop[c]  = pop_any && (gnt_col == COL_W'(c));
      assign f_drop[c] = f_push[c] && f_full[c] && !f_pop[c];

      sum_fifo #(.WIDTH(OFM_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .clr   (start),
         .push  (f_push[c]),
         .din   (ofm.sum[c]),
         .pop   (f_pop[c]),
         .dout  (f_dout[c]),
         .full  (f_full[c]),
         .empty (f_empty[c])
      );
   end

   // First non-empty column at or after rr_ptr, wrapping around.
   // NOTE: every output gets a default before the loop so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_col   = '0;
      for (int i = 0; i < COL; i++) begin
         if (!gnt_valid && !f_empty[COL_W'((int'(rr_ptr) + i) % COL)]) begin
            gnt_valid = 1'b1;
            gnt_col   = COL_W'((int'(rr_ptr) + i) % COL);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_bias_q  <= '0;
         cfg_shift_q <= '0;
         cfg_relu_q  <= 1'b0;
         cfg_total_q <= '0;
         rr_ptr      <= '0;
         s1_valid    <= 1'b0;
         s1_acc      <= '0;
         s1_col      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_col_q   <= '0;
         cnt_q       <= '0;
         done        <= 1'b0;
         ovf         <= 1'b0;
      end else if (start) begin
         cfg_bias_q  <= cfg_bias;
         cfg_shift_q <= cfg_shift;
         cfg_relu_q  <= cfg_relu;
         cfg_total_q <= cfg_total;
         rr_ptr      <= '0;
         s1_valid    <= 1'b0;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
         done        <= 1'b0;
         ovf         <= 1'b0;
      end else begin
         if (|f_drop) ovf <= 1'b1;

         if (pop_any) begin
            rr_ptr <= (gnt_col == COL_W'(COL - 1)) ? '0 : gnt_col + 1'b1;
         end

         if (s1_adv) begin
            s1_valid <= pop_any;
            if (pop_any) begin
               s1_acc <= acc_t'(f_dout[gnt_col]) + acc_t'(cfg_bias_q);
               s1_col <= gnt_col;
            end
         end

         // Data/tag only change on a load, so they stay stable during a stall.
         if (out_load) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
               out_data_q <= requant(s1_acc, cfg_shift_q, cfg_relu_q);
               out_col_q  <= s1_col;
            end
         end

         done <= 1'b0;
         if (hs) begin
            if ((cfg_total_q != '0) && (cnt_q + 1'b1 == cfg_total_q)) begin
               cnt_q <= '0;
               done  <= 1'b1;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_ofm_requant_collector.sv
// ---------------------------------------------------------------------------
// tb_ofm_requant_collector
// Stimulus pushes the expected int8 result for every accepted sum into a
// per-column queue; a monitor pops and compares on each output handshake and
// tracks where the done pulse must appear.
// ---------------------------------------------------------------------------
module tb_ofm_requant_collector;
   import conv_pkg::*;

   localparam int COL        = 8;
   localparam int OFM_WIDTH  = 24;
   localparam int FIFO_DEPTH = 16;
   localparam int CNT_WIDTH  = 20;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic signed [31:0]   cfg_bias;
   logic [4:0]           cfg_shift;
   logic                 cfg_relu;
   logic [CNT_WIDTH-1:0] cfg_total;
   logic                 done;
   logic                 ovf;

   ofm_requant_collector_if #(.COL(COL), .OFM_WIDTH(OFM_WIDTH)) ofm ();

   ofm_requant_collector #(
      .COL(COL), .OFM_WIDTH(OFM_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .CNT_WIDTH(CNT_WIDTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .cfg_bias  (cfg_bias),
      .cfg_shift (cfg_shift),
      .cfg_relu  (cfg_relu),
      .cfg_total (cfg_total),
      .ofm       (ofm),
      .done      (done),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference configuration as the bench believes the DUT holds it.
   int m_bias  = 0;
   int m_shift = 0;
   bit m_relu  = 1'b0;
   int m_total = 0;

   int exp_q [COL][$];
   int log_col [$];
   int log_cyc [$];
   int cyc = 0;

   task automatic check(string name, longint act, longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Requantization from the arithmetic definition: floor division with a
   // half-step added, then ReLU and int8 clamping.
   function automatic int model(int s);
      longint num, d, q;
      num = longint'(s) + longint'(m_bias);
      if (m_shift > 0) begin
         d   = longint'(1) << m_shift;
         num = num + d / 2;
         q   = num / d;
         if ((num % d != 0) && (num < 0)) q = q - 1;
         num = q;
      end
      if (m_relu && num < 0) num = 0;
      if (num > 127)  return 127;
      if (num < -128) return -128;
      return int'(num);
   endfunction

   function automatic int rand_sum();
      if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 4000)) - 2000;
      return int'($urandom) >>> 8;
   endfunction

   function automatic bit all_empty();
      for (int c = 0; c < COL; c++) if (exp_q[c].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_push(int c, int val, bit accept);
      ofm.sum_valid[c] = 1'b1;
      ofm.sum[c]       = OFM_WIDTH'(val);
      if (accept) exp_q[c].push_back(model(val));
   endtask

   task automatic tick_clear();
      tick();
      ofm.sum_valid = '0;
   endtask

   task automatic push1(int c, int val, bit accept);
      set_push(c, val, accept);
      tick_clear();
   endtask

   task automatic do_start(int b, int sh, bit rl, int tot);
      start = 1'b1;
      cfg_bias = b; cfg_shift = 5'(sh); cfg_relu = rl; cfg_total = CNT_WIDTH'(tot);
      m_bias = b; m_shift = sh; m_relu = rl; m_total = tot;
      tick_clear();
      start = 1'b0;
   endtask

   task automatic wait_drain(string name);
      int t = 0;
      ofm.out_ready = 1'b1;
      while (!all_empty() && t < 500) begin
         tick();
         t++;
      end
      if (t >= 500) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: drain timeout, outputs still owed", name);
      end
      repeat (4) tick();
   endtask

   // Monitor / scoreboard.
   initial begin
      bit done_exp = 1'b0;
      int hs_cnt   = 0;
      int col;
      forever begin
         @(negedge clk);
         cyc++;
         check("done", done, done_exp);
         if (rst || start) begin
            for (int c = 0; c < COL; c++) exp_q[c].delete();
            hs_cnt   = 0;
            done_exp = 1'b0;
         end else if (ofm.out_valid && ofm.out_ready) begin
            col = int'(ofm.out_col);
            if (exp_q[col].size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_out: col %0d data %0d, expected no output", col, ofm.out_data);
            end else begin
               check($sformatf("data_col%0d", col), ofm.out_data, exp_q[col].pop_front());
            end
            log_col.push_back(col);
            log_cyc.push_back(cyc);
            hs_cnt++;
            done_exp = (m_total != 0) && (hs_cnt == m_total);
            if (done_exp) hs_cnt = 0;
         end else begin
            done_exp = 1'b0;
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0;
      cfg_bias = '0; cfg_shift = '0; cfg_relu = 1'b0; cfg_total = '0;
      ofm.sum_valid = '0; ofm.out_ready = 1'b1;
      for (int c = 0; c < COL; c++) ofm.sum[c] = '0;
      repeat (3) tick();
      check("rst_out_valid", ofm.out_valid, 0);
      check("rst_out_data", ofm.out_data, 0);
      check("rst_out_col", ofm.out_col, 0);
      check("rst_done", done, 0);
      check("rst_ovf", ovf, 0);
      rst = 1'b0;
      tick();

      // Single sample and latency: (101+10+2)>>2 = 28 on col 3 at N+3.
      do_start(10, 2, 1'b0, 0);
      set_push(3, 101, 1'b1);
      tick_clear();
      tick();
      check("lat_n2_valid", ofm.out_valid, 0);
      tick();
      check("lat_n3_valid", ofm.out_valid, 1);
      check("single_data", ofm.out_data, 28);
      check("single_col", ofm.out_col, 3);
      wait_drain("single");

      // Saturation, ReLU and rounding corners.
      do_start(0, 0, 1'b0, 0);
      push1(0, 300, 1'b1);
      push1(1, -300, 1'b1);
      wait_drain("sat");
      do_start(0, 0, 1'b1, 0);
      push1(2, -5, 1'b1);
      push1(2, 77, 1'b1);
      wait_drain("relu");
      do_start(-3, 3, 1'b0, 0);
      push1(4, 1, 1'b1);
      push1(4, -2, 1'b1);
      push1(4, 8388607, 1'b1);
      wait_drain("round");

      // Round-robin order and done after the 8th handshake.
      do_start(0, 0, 1'b0, 8);
      log_col.delete();
      log_cyc.delete();
      for (int c = 0; c < COL; c++) set_push(c, c, 1'b1);
      tick_clear();
      wait_drain("rr");
      check("rr_count", log_col.size(), 8);
      if (log_col.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            check($sformatf("rr_order%0d", i), log_col[i], i);
            check($sformatf("rr_cycle%0d", i), log_cyc[i] - log_cyc[0], i);
         end
      end

      // Back-pressure: 18 sums fill pipeline (2) and FIFO (16) without loss.
      do_start(0, 0, 1'b0, 0);
      ofm.out_ready = 1'b0;
      for (int v = 1; v <= 18; v++) push1(0, v, 1'b1);
      repeat (2) tick();
      check("bp_no_ovf", ovf, 0);
      check("bp_hold_valid", ofm.out_valid, 1);
      check("bp_hold_data", ofm.out_data, 1);
      // Push into the full FIFO in the same cycle as a pop.
      ofm.out_ready = 1'b1;
      set_push(0, 19, 1'b1);
      tick_clear();
      ofm.out_ready = 1'b0;
      check("pushpop_no_ovf", ovf, 0);
      push1(0, 20, 1'b0);
      check("drop_ovf", ovf, 1);
      check("bp_hold_data2", ofm.out_data, 2);
      wait_drain("bp");
      check("ovf_sticky", ovf, 1);

      // Mid-stream start: counter, ovf and in-flight data are discarded.
      do_start(0, 0, 1'b0, 5);
      push1(0, 1, 1'b1);
      push1(1, 2, 1'b1);
      wait_drain("pre_start");
      ofm.out_ready = 1'b0;
      for (int i = 0; i < 19; i++) push1(6, i, i < 18);
      check("ovf_before_start", ovf, 1);
      set_push(2, 123, 1'b0);
      do_start(7, 1, 1'b1, 3);
      check("start_flush_valid", ofm.out_valid, 0);
      check("start_clr_ovf", ovf, 0);
      ofm.out_ready = 1'b1;
      repeat (5) tick();
      push1(1, -9, 1'b1);
      push1(1, 20, 1'b1);
      push1(1, 300, 1'b1);
      wait_drain("post_start");

      // rst together with start: reset values and cfg back to zero.
      ofm.out_ready = 1'b0;
      for (int i = 0; i < 19; i++) push1(6, i, i < 18);
      check("ovf_before_rst", ovf, 1);
      rst = 1'b1;
      start = 1'b1;
      cfg_bias = 5; cfg_shift = 1; cfg_relu = 1'b1; cfg_total = 2;
      m_bias = 0; m_shift = 0; m_relu = 1'b0; m_total = 0;
      tick();
      rst = 1'b0;
      start = 1'b0;
      check("rst_start_valid", ofm.out_valid, 0);
      check("rst_start_data", ofm.out_data, 0);
      check("rst_start_col", ofm.out_col, 0);
      check("rst_start_ovf", ovf, 0);
      check("rst_start_done", done, 0);
      ofm.out_ready = 1'b1;
      push1(0, 9, 1'b1);
      push1(5, -200, 1'b1);
      wait_drain("rst_cfg");

      // Randomized traffic, never exceeding what the FIFOs can hold.
      for (int r = 0; r < 3; r++) begin
         int b;
         b = ($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 2000)) - 1000;
         do_start(b, (r == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 31)),
                  bit'($urandom_range(0, 1)), int'($urandom_range(1, 40)));
         for (int t = 0; t < 1500; t++) begin
            ofm.out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < COL; c++) begin
               if ($urandom_range(0, 3) == 0 && exp_q[c].size() < FIFO_DEPTH)
                  set_push(c, rand_sum(), 1'b1);
            end
            tick_clear();
         end
         wait_drain("rand");
         check("rand_no_ovf", ovf, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
